// File: rtl/dis_dffr_bank_ctrl_if.sv
// Requester-side write bus shared by all requesters of the dis_dffr register bank.
// Each requester owns a slice of the packed address/data vectors.
interface dis_dffr_bank_ctrl_if #(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 8,
    parameter int AW      = 2
);
    logic [NUM_REQ-1:0]       req_valid_i;
    logic [NUM_REQ-1:0]       req_ready_o;
    logic [NUM_REQ*AW-1:0]    req_addr_i;
    logic [NUM_REQ*WIDTH-1:0] req_data_i;

    modport master (
        output req_valid_i,
        output req_addr_i,
        output req_data_i,
        input  req_ready_o
    );

    modport slave (
        input  req_valid_i,
        input  req_addr_i,
        input  req_data_i,
        output req_ready_o
    );
endinterface

// File: rtl/dis_dffr_bank_ctrl.sv
// Round-robin write controller for a bank of dis_dffr_led register words.
// Define LAMP_TEST_EN to build the lamp-test sequencer (LT_ON/LT_OFF states).
module dis_dffr_bank_ctrl #(
    parameter int NUM_REQ   = 2,
    parameter int NUM_WORDS = 4,
    parameter int WIDTH     = 8,
    parameter int AW        = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
    parameter int LT_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    dis_dffr_bank_ctrl_if.slave   bus,
    output logic [NUM_WORDS-1:0]  word_dis_o,
    output logic [WIDTH-1:0]      word_d_o,
    output logic                  addr_err_o,
    output logic                  busy_o,
    input  logic                  lamp_test_i,
    output logic                  lamp_done_o
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW:0] NW_L = (AW+1)'(NUM_WORDS);

    logic [PW-1:0]        ptr_q, ptr_d, gnt_idx_s;
    logic                 gnt_any_s, can_grant_s, xfer_s, in_range_s;
    logic [NUM_REQ-1:0]   gnt_s;
    logic [AW-1:0]        sel_addr_s;
    logic [WIDTH-1:0]     sel_data_s;
    logic [NUM_WORDS-1:0] word_dis_q, word_dis_d;
    logic [WIDTH-1:0]     word_d_q, word_d_d;
    logic                 addr_err_q, addr_err_d;

`ifdef LAMP_TEST_EN
    localparam int CW = (LT_CYCLES > 1) ? $clog2(LT_CYCLES) : 1;
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LT_ON = 2'd1, ST_LT_OFF = 2'd2} state_t;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          lamp_done_q, lamp_done_d;
`else
    logic          unused_lamp_s;
    assign unused_lamp_s = lamp_test_i | (LT_CYCLES < 1);
`endif

    // Round-robin pick: scanning from the far end lets the requester nearest the pointer win.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_idx_s = ptr_q;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx       = (int'(ptr_q) + i) % NUM_REQ;
            gnt_idx_s = bus.req_valid_i[idx] ? PW'(idx) : gnt_idx_s;
        end
        gnt_any_s  = |bus.req_valid_i;
        gnt_s      = {NUM_REQ{1'b0}};
        gnt_s[gnt_idx_s] = gnt_any_s;
        sel_addr_s = bus.req_addr_i[gnt_idx_s*AW +: AW];
        sel_data_s = bus.req_data_i[gnt_idx_s*WIDTH +: WIDTH];
        in_range_s = {1'b0, sel_addr_s} < NW_L;
    end

    // Grant gating: no transfers during reset, lamp-test entry or lamp-test states.
    always_comb begin
`ifdef LAMP_TEST_EN
        can_grant_s = !rst_i && (state_q == ST_IDLE) && !lamp_test_i;
`else
        can_grant_s = !rst_i;
`endif
        xfer_s          = can_grant_s & gnt_any_s;
        bus.req_ready_o = can_grant_s ? gnt_s : {NUM_REQ{1'b0}};
    end

    // Next-state: the write path is the idle behaviour; lamp-test states override it.
    always_comb begin
        ptr_d      = ptr_q;
        word_dis_d = {NUM_WORDS{1'b1}};
        word_d_d   = word_d_q;
        addr_err_d = 1'b0;
        if (xfer_s) begin
            ptr_d    = (gnt_idx_s == PW'(NUM_REQ - 1)) ? {PW{1'b0}} : gnt_idx_s + PW'(1);
            word_d_d = sel_data_s;
            if (in_range_s) begin
                word_dis_d[sel_addr_s] = 1'b0;
            end else begin
                addr_err_d = 1'b1;
            end
        end else begin
            ptr_d = ptr_q;
        end
`ifdef LAMP_TEST_EN
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        lamp_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (lamp_test_i) begin
                    state_d    = ST_LT_ON;
                    cnt_d      = {CW{1'b0}};
                    busy_d     = 1'b1;
                    word_dis_d = {NUM_WORDS{1'b0}};
                    word_d_d   = {WIDTH{1'b1}};
                end else begin
                    busy_d = 1'b0;
                end
            end
            ST_LT_ON: begin
                busy_d     = 1'b1;
                word_dis_d = {NUM_WORDS{1'b0}};
                if (cnt_q == CW'(LT_CYCLES - 1)) begin
                    state_d  = ST_LT_OFF;
                    cnt_d    = {CW{1'b0}};
                    word_d_d = {WIDTH{1'b0}};
                end else begin
                    cnt_d    = cnt_q + CW'(1);
                    word_d_d = {WIDTH{1'b1}};
                end
            end
            ST_LT_OFF: begin
                state_d     = ST_IDLE;
                busy_d      = 1'b0;
                lamp_done_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CW{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
`endif
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q       <= {PW{1'b0}};
            word_dis_q  <= {NUM_WORDS{1'b1}};
            word_d_q    <= {WIDTH{1'b0}};
            addr_err_q  <= 1'b0;
`ifdef LAMP_TEST_EN
            state_q     <= ST_IDLE;
            cnt_q       <= {CW{1'b0}};
            busy_q      <= 1'b0;
            lamp_done_q <= 1'b0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            word_dis_q  <= word_dis_d;
            word_d_q    <= word_d_d;
            addr_err_q  <= addr_err_d;
`ifdef LAMP_TEST_EN
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            lamp_done_q <= lamp_done_d;
`endif
        end
    end

    assign word_dis_o = word_dis_q;
    assign word_d_o   = word_d_q;
    assign addr_err_o = addr_err_q;
`ifdef LAMP_TEST_EN
    assign busy_o      = busy_q;
    assign lamp_done_o = lamp_done_q;
`else
    assign busy_o      = 1'b0;
    assign lamp_done_o = 1'b0;
`endif
endmodule

// File: tb/tb_dis_dffr_bank_ctrl.sv
// Directed plus randomized bench for dis_dffr_bank_ctrl with a behavioural bank model.
// The same bench covers builds with and without LAMP_TEST_EN.
module tb_dis_dffr_bank_ctrl;
    localparam int NR = 2;
    localparam int NW = 3;
    localparam int W  = 8;
    localparam int AW = 2;
    localparam int LT = 4;
`ifdef LAMP_TEST_EN
    localparam bit LT_EN = 1'b1;
`else
    localparam bit LT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          lamp;
    logic [NW-1:0] word_dis;
    logic [W-1:0]  word_d;
    logic          addr_err, busy, lamp_done;

    dis_dffr_bank_ctrl_if #(.NUM_REQ(NR), .WIDTH(W), .AW(AW)) bus ();

    dis_dffr_bank_ctrl #(.NUM_REQ(NR), .NUM_WORDS(NW), .WIDTH(W), .AW(AW), .LT_CYCLES(LT)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .word_dis_o(word_dis), .word_d_o(word_d),
        .addr_err_o(addr_err), .busy_o(busy), .lamp_test_i(lamp), .lamp_done_o(lamp_done)
    );

    always #5 clk = ~clk;

    // Register bank built from the controller's outputs, as the real cells would see them.
    logic [W-1:0] tb_bank [NW];
    always @(posedge clk) begin
        for (int w = 0; w < NW; w++) begin
            if (word_dis[w] === 1'b0) tb_bank[w] <= word_d;
        end
    end

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 lamps on, 2 lamps off.
    int            m_ptr, m_mode, m_on_cycles;
    logic [NW-1:0] m_dis;
    logic [W-1:0]  m_d;
    bit            m_err, m_busy, m_done;
    logic [W-1:0]  m_bank [NW];
    bit            m_known [NW];
    logic [NR-1:0] last_r;
    bit            pend [NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [NR-1:0] exp_ready();
        logic [NR-1:0] r;
        r = '0;
        if (rst || m_mode != 0 || (LT_EN && lamp)) return r;
        for (int off = 0; off < NR; off++) begin
            int k;
            k = (m_ptr + off) % NR;
            if (bus.req_valid_i[k]) begin
                r[k] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic model_edge(input logic [NR-1:0] r);
        for (int w = 0; w < NW; w++) begin
            if (!m_dis[w]) begin
                m_bank[w]  = m_d;
                m_known[w] = 1'b1;
            end
        end
        m_err  = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_dis = '1; m_d = '0; m_busy = 1'b0;
            m_ptr = 0; m_mode = 0; m_on_cycles = 0;
        end else if (m_mode == 0) begin
            m_dis = '1;
            if (LT_EN && lamp) begin
                m_mode = 1; m_on_cycles = 0;
                m_dis = '0; m_d = '1; m_busy = 1'b1;
            end else if (r != 0) begin
                for (int k = 0; k < NR; k++) begin
                    if (r[k]) begin
                        int a;
                        a   = int'(bus.req_addr_i[k*AW +: AW]);
                        m_d = bus.req_data_i[k*W +: W];
                        if (a < NW) m_dis[a] = 1'b0;
                        else m_err = 1'b1;
                        m_ptr = (k + 1) % NR;
                    end
                end
            end
        end else if (m_mode == 1) begin
            m_on_cycles++;
            if (m_on_cycles == LT) begin
                m_mode = 2;
                m_d    = '0;
            end
        end else begin
            m_mode = 0; m_dis = '1; m_busy = 1'b0; m_done = 1'b1;
        end
    endtask

    // One clock: check ready with inputs settled, advance the model, check registered outputs.
    task automatic cycle();
        #1;
        last_r = exp_ready();
        chk("req_ready", 32'(bus.req_ready_o), 32'(last_r));
        @(posedge clk);
        model_edge(last_r);
        #1;
        chk("word_dis", 32'(word_dis), 32'(m_dis));
        chk("word_d", 32'(word_d), 32'(m_d));
        chk("addr_err", 32'(addr_err), 32'(m_err));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("lamp_done", 32'(lamp_done), 32'(m_done));
        for (int w = 0; w < NW; w++) begin
            if (m_known[w]) chk("bank_word", 32'(tb_bank[w]), 32'(m_bank[w]));
        end
        #1;
    endtask

    task automatic set_req(input int k, input bit v, input int a, input int d);
        bus.req_valid_i[k]          = v;
        bus.req_addr_i[k*AW +: AW]  = a[AW-1:0];
        bus.req_data_i[k*W +: W]    = d[W-1:0];
    endtask

    initial begin
        rst = 1'b1; lamp = 1'b0;
        bus.req_valid_i = '0; bus.req_addr_i = '0; bus.req_data_i = '0;
        m_ptr = 0; m_mode = 0; m_on_cycles = 0;
        m_dis = '1; m_d = '0; m_err = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        for (int w = 0; w < NW; w++) begin m_known[w] = 1'b0; m_bank[w] = '0; end
        for (int k = 0; k < NR; k++) pend[k] = 1'b0;

        // Reset with inputs toggling
        for (int i = 0; i < 2; i++) begin
            bus.req_valid_i = NR'($urandom);
            bus.req_addr_i  = (NR*AW)'($urandom);
            bus.req_data_i  = (NR*W)'($urandom);
            lamp            = 1'($urandom);
            cycle();
        end
        rst = 1'b0; lamp = 1'b0; bus.req_valid_i = '0;
        cycle();

        // Single write to word 2
        set_req(0, 1'b1, 2, 'hA5);
        cycle();
        set_req(0, 1'b0, 0, 0);
        cycle();
        cycle();

        // Contention: both requesters continuously valid
        set_req(0, 1'b1, 0, 'h11);
        set_req(1, 1'b1, 1, 'h22);
        repeat (6) cycle();
        bus.req_valid_i = '0;
        cycle();

        // Out-of-range address
        set_req(1, 1'b1, 3, 'hFF);
        cycle();
        set_req(1, 1'b0, 0, 0);
        cycle();
        cycle();

        // Lamp test with a simultaneous request, then reset in the 2nd LT_ON cycle
        lamp = 1'b1;
        set_req(0, 1'b1, 1, 'h3C);
        cycle();
        lamp = 1'b0;
        repeat (7) cycle();
        bus.req_valid_i = '0;
        cycle();
        lamp = 1'b1;
        cycle();
        lamp = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Randomized traffic with stable-until-transfer requesters
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NR; k++) begin
                if (!pend[k] && ($urandom % 3 != 0)) begin
                    pend[k] = 1'b1;
                    set_req(k, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
                end
            end
            lamp = ($urandom % 20 == 0);
            rst  = ($urandom % 60 == 0);
            cycle();
            for (int k = 0; k < NR; k++) begin
                if (last_r[k]) begin
                    pend[k] = 1'b0;
                    bus.req_valid_i[k] = 1'b0;
                end
            end
        end
        rst = 1'b0; lamp = 1'b0; bus.req_valid_i = '0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
